// File: rtl/adc_frame_sequencer.sv
// adc_frame_sequencer: per-sample-tick ADC convert/readout sequencer publishing coherent multi-channel frames (optional busy timeout via ADC_SEQ_TIMEOUT_EN)
module adc_frame_sequencer #(
    parameter int NUM_CH        = 10,
    parameter int SAMPLE_PERIOD = 1000,
    parameter int CONVST_CYCLES = 4,
    parameter int BUSY_TIMEOUT  = 4096,
    localparam int CH_W         = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic                   clr_overrun_i,
    input  logic                   busy_i,
    output logic                   convst_o,
    output logic                   rd_req_o,
    output logic [CH_W-1:0]        rd_ch_o,
    input  logic                   rd_ack_i,
    input  logic [31:0]            rd_data_i,
    output logic [32*NUM_CH-1:0]   frame_data_o,
    output logic                   frame_valid_o,
    output logic [31:0]            osync_o,
    output logic                   overrun_o,
    output logic                   timeout_o
);
    localparam int SP_W = $clog2(SAMPLE_PERIOD);
    localparam int CC_W = $clog2(CONVST_CYCLES + 1);
    localparam int TW   = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CONV, WAIT_BUSY, READ, PUBLISH} state_t;

    state_t              state;
    logic [SP_W-1:0]     cnt;
    logic                tick;
    logic [CC_W-1:0]     cc;
    logic [TW-1:0]       wcnt;
    logic [32*NUM_CH-1:0] shadow;

    assign tick = en_i && (cnt == SP_W'(SAMPLE_PERIOD - 1));

`ifndef ADC_SEQ_TIMEOUT_EN
    assign timeout_o = 1'b0;
`endif

    // sample grid counter, parked at zero while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= !en_i || tick ? '0 : cnt + 1'b1;
    end

    // frame sequencer; rd_ch_o doubles as the channel index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cc            <= '0;
            wcnt          <= '0;
            shadow        <= '0;
            convst_o      <= 1'b0;
            rd_req_o      <= 1'b0;
            rd_ch_o       <= '0;
            frame_data_o  <= '0;
            frame_valid_o <= 1'b0;
            osync_o       <= '0;
            overrun_o     <= 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
            timeout_o     <= 1'b0;
`endif
        end else begin
            frame_valid_o <= 1'b0;
            if (clr_overrun_i)
                overrun_o <= 1'b0;
            if (tick && state != IDLE)
                overrun_o <= 1'b1;
`ifdef ADC_SEQ_TIMEOUT_EN
            if (clr_overrun_i)
                timeout_o <= 1'b0;
`endif
            case (state)
                IDLE: if (tick) begin
                    state    <= CONV;
                    convst_o <= 1'b1;
                    cc       <= '0;
                end
                CONV: if (cc == CC_W'(CONVST_CYCLES - 1)) begin
                    convst_o <= 1'b0;
                    wcnt     <= '0;
                    state    <= WAIT_BUSY;
                end else begin
                    cc <= cc + 1'b1;
                end
                WAIT_BUSY: if (wcnt != '0 && !busy_i) begin
                    state    <= READ;
                    rd_req_o <= 1'b1;
                    rd_ch_o  <= '0;
`ifdef ADC_SEQ_TIMEOUT_EN
                end else if (wcnt == TW'(BUSY_TIMEOUT - 1)) begin
                    state     <= IDLE;
                    timeout_o <= 1'b1;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
`else
                end else begin
                    wcnt <= TW'(1);
                end
`endif
                READ: if (!rd_req_o) begin
                    rd_req_o <= 1'b1;
                end else if (rd_ack_i) begin
                    shadow[32*rd_ch_o +: 32] <= rd_data_i;
                    rd_req_o <= 1'b0;
                    if (rd_ch_o == CH_W'(NUM_CH - 1))
                        state <= PUBLISH;
                    else
                        rd_ch_o <= rd_ch_o + 1'b1;
                end
                PUBLISH: begin
                    frame_data_o  <= shadow;
                    frame_valid_o <= 1'b1;
                    osync_o       <= osync_o + 32'd1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_frame_sequencer.sv
// tb_adc_frame_sequencer: scoreboard bench with ADC busy and serial readout models
module tb_adc_frame_sequencer;
    localparam int NUM_CH = 3;
    localparam int SP     = 50;
    localparam int CC     = 4;
    localparam int BT     = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_i = 1'b0;
    logic        clr_overrun_i = 1'b0;
    logic        busy_i = 1'b0;
    logic        rd_ack_i = 1'b0;
    logic [31:0] rd_data_i = '0;
    logic        convst_o, rd_req_o, frame_valid_o, overrun_o, timeout_o;
    logic [1:0]  rd_ch_o;
    logic [95:0] frame_data_o;
    logic [31:0] osync_o;

    always #5 clk = ~clk;

    adc_frame_sequencer #(
        .NUM_CH(NUM_CH), .SAMPLE_PERIOD(SP), .CONVST_CYCLES(CC), .BUSY_TIMEOUT(BT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_overrun_i(clr_overrun_i),
        .busy_i(busy_i), .convst_o(convst_o), .rd_req_o(rd_req_o), .rd_ch_o(rd_ch_o),
        .rd_ack_i(rd_ack_i), .rd_data_i(rd_data_i), .frame_data_o(frame_data_o),
        .frame_valid_o(frame_valid_o), .osync_o(osync_o), .overrun_o(overrun_o),
        .timeout_o(timeout_o)
    );

    typedef struct packed {
        logic [95:0] d;
        logic [31:0] s;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          conv_rises = 0;
    int          frames_seen = 0;
    int          exp_frames = 0;
    longint      cyc = 0;
    longint      rise_cyc = 0;
    logic        ack_hold = 1'b0;
    logic        busy_stuck = 1'b0;
    logic [31:0] data_tab [NUM_CH];

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event", nm);
    endtask

    task automatic push(input logic [95:0] d, input logic [31:0] s);
        q.push_back('{d: d, s: s});
        exp_frames++;
    endtask

    task automatic wait_rise(output int n);
        int s;
        s = conv_rises;
        n = 0;
        while (conv_rises == s && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (conv_rises == s) fail("convst_wait");
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (!rd_req_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rd_req_o) fail("req_wait");
    endtask

    task automatic wait_frames(input int t);
        int n;
        n = 0;
        while (frames_seen < t && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (frames_seen < t) fail("frame_wait");
    endtask

    // ADC converter: busy while converting, drops 3 cycles after convst falls
    initial begin
        int bc;
        bc = 0;
        forever begin
            @(negedge clk);
            if (convst_o) begin
                busy_i = 1'b1;
                bc = 3;
            end else if (!busy_stuck && busy_i) begin
                if (bc > 0) bc--;
                if (bc == 0) busy_i = 1'b0;
            end
        end
    end

    // serial readout engine: ack 2 cycles after a request
    initial begin
        forever begin
            @(negedge clk);
            if (rd_req_o && !ack_hold && rst_n) begin
                @(negedge clk);
                rd_data_i = data_tab[rd_ch_o];
                rd_ack_i = 1'b1;
                @(negedge clk);
                rd_ack_i = 1'b0;
            end
        end
    end

    // monitor: convst edges, scoreboard pops, frame coherence
    initial begin
        logic        prev_conv;
        logic [95:0] last;
        exp_t        e;
        prev_conv = 1'b0;
        last = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (convst_o && !prev_conv) begin
                conv_rises++;
                rise_cyc = cyc;
            end
            prev_conv = convst_o;
            if (!rst_n) begin
                last = frame_data_o;
            end else if (frame_valid_o) begin
                frames_seen++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame actual=%0h/%0h required=none", frame_data_o, osync_o);
                end else begin
                    e = q.pop_front();
                    chk("sb_frame_data", frame_data_o, e.d);
                    chk("sb_osync", osync_o, e.s);
                end
                last = frame_data_o;
            end else begin
                chk("frame_coherent", frame_data_o, last);
            end
        end
    end

    initial begin
        int     n, w, r0;
        logic   seen;
        longint r1;
        data_tab = '{32'h11, 32'h22, 32'h33};
        repeat (3) @(negedge clk);
        chk("rst_convst", convst_o, 0);
        chk("rst_rd_req", rd_req_o, 0);
        chk("rst_rd_ch", rd_ch_o, 0);
        chk("rst_frame_data", frame_data_o, 0);
        chk("rst_frame_valid", frame_valid_o, 0);
        chk("rst_osync", osync_o, 0);
        chk("rst_overrun", overrun_o, 0);
        chk("rst_timeout", timeout_o, 0);
        rst_n = 1'b1;

        repeat (500) @(negedge clk);
        chk("en_low_no_convst", conv_rises, 0);

        push(96'h00000033_00000022_00000011, 32'd1);
        push(96'h00000033_00000022_00000011, 32'd2);
        en_i = 1'b1;
        wait_rise(n);
        chk("en_to_convst_window", (n == SP || n == SP + 1), 1);
        r1 = rise_cyc;
        w = 0;
        while (convst_o && w < 20) begin
            w++;
            @(negedge clk);
        end
        chk("convst_width", w, CC);
        wait_frames(1);
        chk("f1_osync", osync_o, 1);
        chk("f1_data", frame_data_o, 96'h00000033_00000022_00000011);
        @(negedge clk);
        chk("valid_one_cycle", frame_valid_o, 0);
        wait_rise(n);
        chk("frame_period", rise_cyc - r1, SP);
        en_i = 1'b0;
        wait_frames(2);
        chk("f2_osync", osync_o, 2);
        chk("no_overrun_normal", overrun_o, 0);

        data_tab = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
        push(96'h89ABCDEF_01234567_DEADBEEF, 32'd3);
        ack_hold = 1'b1;
        en_i = 1'b1;
        wait_rise(n);
        r0 = conv_rises;
        wait_req();
        repeat (200) @(negedge clk);
        chk("hold_no_second_convst", conv_rises - r0, 0);
        chk("hold_overrun_set", overrun_o, 1);
        en_i = 1'b0;
        ack_hold = 1'b0;
        wait_frames(3);
        chk("f3_osync", osync_o, 3);
        chk("overrun_sticky", overrun_o, 1);
        clr_overrun_i = 1'b1;
        @(negedge clk);
        clr_overrun_i = 1'b0;
        chk("overrun_cleared", overrun_o, 0);

        data_tab = '{32'h000000AA, 32'h55555555, 32'hFFFFFFFF};
        push(96'hFFFFFFFF_55555555_000000AA, 32'd4);
        ack_hold = 1'b1;
        en_i = 1'b1;
        wait_rise(n);
        wait_req();
        clr_overrun_i = 1'b1;
        seen = 1'b0;
        repeat (120) begin
            @(negedge clk);
            if (overrun_o) seen = 1'b1;
        end
        chk("set_beats_clear", seen, 1);
        en_i = 1'b0;
        @(negedge clk);
        clr_overrun_i = 1'b0;
        @(negedge clk);
        chk("clear_after_set", overrun_o, 0);
        ack_hold = 1'b0;
        wait_frames(4);
        chk("f4_osync", osync_o, 4);

`ifdef ADC_SEQ_TIMEOUT_EN
        busy_stuck = 1'b1;
        en_i = 1'b1;
        wait_rise(n);
        en_i = 1'b0;
        w = 0;
        while (convst_o && w < 20) begin
            w++;
            @(negedge clk);
        end
        n = 0;
        while (!timeout_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, BT);
        repeat (20) @(negedge clk);
        chk("timeout_no_frame", frames_seen, exp_frames);
        chk("timeout_osync", osync_o, 4);
        chk("timeout_no_req", rd_req_o, 0);
        busy_stuck = 1'b0;
        clr_overrun_i = 1'b1;
        @(negedge clk);
        clr_overrun_i = 1'b0;
        chk("timeout_cleared", timeout_o, 0);
`else
        data_tab = '{32'h00C0FFEE, 32'hCAFEBABE, 32'h0BADF00D};
        push(96'h0BADF00D_CAFEBABE_00C0FFEE, 32'd5);
        busy_stuck = 1'b1;
        en_i = 1'b1;
        wait_rise(n);
        en_i = 1'b0;
        repeat (100) @(negedge clk);
        chk("stuck_no_req", rd_req_o, 0);
        chk("stuck_timeout_tied", timeout_o, 0);
        busy_stuck = 1'b0;
        wait_frames(5);
        chk("f5_osync", osync_o, 5);
`endif

        force dut.osync_o = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.osync_o;
        @(negedge clk);
        data_tab = '{32'h1, 32'h2, 32'h3};
        push(96'h00000003_00000002_00000001, 32'd0);
        en_i = 1'b1;
        wait_rise(n);
        en_i = 1'b0;
        wait_frames(exp_frames);
        chk("osync_wrap", osync_o, 0);
        chk("wrap_data", frame_data_o, 96'h00000003_00000002_00000001);

        data_tab = '{32'h77, 32'h88, 32'h99};
        ack_hold = 1'b1;
        en_i = 1'b1;
        wait_rise(n);
        wait_req();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_convst", convst_o, 0);
        chk("mid_rst_rd_req", rd_req_o, 0);
        chk("mid_rst_rd_ch", rd_ch_o, 0);
        chk("mid_rst_frame_data", frame_data_o, 0);
        chk("mid_rst_frame_valid", frame_valid_o, 0);
        chk("mid_rst_osync", osync_o, 0);
        chk("mid_rst_overrun", overrun_o, 0);
        chk("mid_rst_timeout", timeout_o, 0);
        en_i = 1'b0;
        ack_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("abandoned_no_frame", frames_seen, exp_frames);
        chk("abandoned_osync", osync_o, 0);
        chk("sb_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
